// File: rtl/sync_fifo_drain_ctrl.sv
// Read-side drain controller for a synchronous FIFO with one-cycle registered read data.
//
// Pops words from the upstream FIFO and holds them in a 2-entry skid buffer. The buffer
// absorbs the FIFO read latency, so the sink can stall without losing data. Words leave
// the block on a valid/ready stream. Each word carries a frame delimiter (out_last), and
// the block keeps word-in-frame and completed-frame counters.
//
// Ports:
//   clk            rising-edge clock, single domain
//   rst_           asynchronous reset, active low
//   en             1 = fetch from FIFO, 0 = stop fetching and drain what is buffered
//   fifo_empty     upstream FIFO empty flag
//   fifo_data_out  upstream read data, valid the cycle after fifo_read
//   fifo_read      pop request to the FIFO (combinational)
//   out_valid      out_data / out_last valid
//   out_ready      sink accepts the head word when out_valid && out_ready
//   out_data       head of the skid buffer
//   out_last       head word is the last word of a frame
//   word_cnt       position of the head word in the current frame
//   frame_cnt      completed frames, wraps
//   busy           controller is not idle
module sync_fifo_drain_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAME_LEN  = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_read,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0] LastIdx = CNT_WIDTH'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } state_e;

  state_e                state_q;
  logic                  busy_q;

  // Skid buffer: buf0 is always the head, buf1 the second entry.
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q;

  logic [CNT_WIDTH-1:0]  word_cnt_q;
  logic [CNT_WIDTH-1:0]  frame_cnt_q;

  logic                  pop;
  logic                  at_last;
  logic [2:0]            occ_after;
  logic                  drained;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = buf0_q;
  assign pop       = out_valid && out_ready;
  assign at_last   = (word_cnt_q == LastIdx);
  assign out_last  = out_valid && at_last;
  assign word_cnt  = word_cnt_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = busy_q;

  // Slots committed after this edge: buffered words plus the word in flight, minus the
  // word leaving now. A new read is allowed only if its data will still have a slot.
  assign occ_after = 3'(count_q) + 3'(inflight_q) - 3'(pop);

  // Gated by rst_ so no pop request escapes while reset is held.
  assign fifo_read = rst_ && en && !fifo_empty && (occ_after < 3'd2);

  // Buffer next state. Write-without-pop into a full buffer cannot occur because
  // fifo_read reserves the slot a cycle ahead; it is ignored defensively.
  always_comb begin
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    count_d = count_q;
    case ({inflight_q, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          buf0_d  = fifo_data_out;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          buf1_d  = fifo_data_out;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        buf0_d  = buf1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          buf0_d = fifo_data_out;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_data_out;
        end
      end
      default: ;
    endcase
  end

  // Nothing buffered and nothing arriving after this edge.
  assign drained = (count_d == 2'd0) && !fifo_read;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      count_q    <= count_d;
      inflight_q <= fifo_read;
    end
  end

  // Frame position follows accepted words only; en gaps never clear it.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      word_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else if (pop) begin
      if (at_last) begin
        word_cnt_q  <= '0;
        frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
      end else begin
        word_cnt_q  <= word_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Control FSM. DRAIN leaves for IDLE on the edge that empties the buffer, so busy
  // drops in the cycle after the final pop.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (en) begin
            state_q <= StFetch;
            busy_q  <= 1'b1;
          end
        end
        StFetch: begin
          if (!en) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (en) begin
            state_q <= StFetch;
          end else if (drained) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_drain_ctrl.sv
// Directed bench for sync_fifo_drain_ctrl. Instance a uses FRAME_LEN=16, instance b
// uses FRAME_LEN=4. Each instance is fed by a small behavioural FIFO with registered
// read data. Inputs are driven on the falling edge; outputs are sampled 1 ns later.
module tb_sync_fifo_drain_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_;

  logic        en_a, empty_a, fread_a, valid_a, ready_a, last_a, busy_a;
  logic [15:0] fdata_a, data_a;
  logic [7:0]  wcnt_a, fcnt_a;
  logic [15:0] mem_a [256];
  int          wr_a = 0;
  int          rd_a = 0;

  logic        en_b, empty_b, fread_b, valid_b, ready_b, last_b, busy_b;
  logic [15:0] fdata_b, data_b;
  logic [7:0]  wcnt_b, fcnt_b;
  logic [15:0] mem_b [256];
  int          wr_b = 0;
  int          rd_b = 0;

  int checks = 0;
  int errors = 0;

  assign empty_a = (rd_a == wr_a);
  assign empty_b = (rd_b == wr_b);

  always @(posedge clk) begin
    if (fread_a) begin
      fdata_a <= mem_a[rd_a[7:0]];
      rd_a    <= rd_a + 1;
    end
  end

  always @(posedge clk) begin
    if (fread_b) begin
      fdata_b <= mem_b[rd_b[7:0]];
      rd_b    <= rd_b + 1;
    end
  end

  sync_fifo_drain_ctrl #(
    .DATA_WIDTH(16),
    .FRAME_LEN (16),
    .CNT_WIDTH (8)
  ) dut_a (
    .clk          (clk),
    .rst_         (rst_),
    .en           (en_a),
    .fifo_empty   (empty_a),
    .fifo_data_out(fdata_a),
    .fifo_read    (fread_a),
    .out_valid    (valid_a),
    .out_ready    (ready_a),
    .out_data     (data_a),
    .out_last     (last_a),
    .word_cnt     (wcnt_a),
    .frame_cnt    (fcnt_a),
    .busy         (busy_a)
  );

  sync_fifo_drain_ctrl #(
    .DATA_WIDTH(16),
    .FRAME_LEN (4),
    .CNT_WIDTH (8)
  ) dut_b (
    .clk          (clk),
    .rst_         (rst_),
    .en           (en_b),
    .fifo_empty   (empty_b),
    .fifo_data_out(fdata_b),
    .fifo_read    (fread_b),
    .out_valid    (valid_b),
    .out_ready    (ready_b),
    .out_data     (data_b),
    .out_last     (last_b),
    .word_cnt     (wcnt_b),
    .frame_cnt    (fcnt_b),
    .busy         (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) begin
      mem_a[wr_a[7:0]] = base + 16'(k);
      wr_a = wr_a + 1;
    end
  endtask

  task automatic load_b(input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) begin
      mem_b[wr_b[7:0]] = base + 16'(k);
      wr_b = wr_b + 1;
    end
  endtask

  initial begin
    rst_    = 1'b0;
    en_a    = 1'b0;
    ready_a = 1'b1;
    en_b    = 1'b0;
    ready_b = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_fread", 32'(fread_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_last", 32'(last_a), 32'd0);
    check("rst_wcnt", 32'(wcnt_a), 32'd0);
    check("rst_fcnt", 32'(fcnt_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_b_busy", 32'(busy_b), 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);

    // Burst of 16 words at full rate, one frame of 16
    load_a(16, 16'h0001);
    en_a = 1'b1;
    for (int i = 0; i < 18; i++) begin
      #1;
      check($sformatf("t2_fread_%0d", i), 32'(fread_a), 32'(i < 16));
      check($sformatf("t2_valid_%0d", i), 32'(valid_a), 32'(i >= 2));
      if (i >= 2) check($sformatf("t2_data_%0d", i), 32'(data_a), 32'(i - 1));
      check($sformatf("t2_last_%0d", i), 32'(last_a), 32'(i == 17));
      if (i >= 1) check($sformatf("t2_busy_%0d", i), 32'(busy_a), 32'd1);
      @(negedge clk);
    end
    #1;
    check("t2_valid_end", 32'(valid_a), 32'd0);
    check("t2_fcnt", 32'(fcnt_a), 32'd1);
    check("t2_wcnt", 32'(wcnt_a), 32'd0);

    // Backpressure after the first word
    @(negedge clk);
    load_a(16, 16'h0101);
    #1;
    check("t3_fread_c0", 32'(fread_a), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t3_valid_c2", 32'(valid_a), 32'd1);
    check("t3_data_c2", 32'(data_a), 32'h0101);
    @(negedge clk);
    ready_a = 1'b0;
    #1;
    check("t3_fread_stop", 32'(fread_a), 32'd0);
    check("t3_data_c3", 32'(data_a), 32'h0102);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("t3_hold_fread_%0d", i), 32'(fread_a), 32'd0);
      check($sformatf("t3_hold_valid_%0d", i), 32'(valid_a), 32'd1);
      check($sformatf("t3_hold_data_%0d", i), 32'(data_a), 32'h0102);
    end
    @(negedge clk);
    ready_a = 1'b1;
    for (int i = 0; i < 15; i++) begin
      #1;
      check($sformatf("t3_valid_%0d", i), 32'(valid_a), 32'd1);
      check($sformatf("t3_data_%0d", i), 32'(data_a), 32'h0102 + 32'(i));
      check($sformatf("t3_last_%0d", i), 32'(last_a), 32'(i == 14));
      @(negedge clk);
    end
    #1;
    check("t3_valid_end", 32'(valid_a), 32'd0);
    check("t3_fcnt", 32'(fcnt_a), 32'd2);
    check("t3_wcnt", 32'(wcnt_a), 32'd0);

    // en dropped after the 5th read
    @(negedge clk);
    load_a(8, 16'h0201);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t5_fread_%0d", i), 32'(fread_a), 32'd1);
      if (i >= 2) check($sformatf("t5_data_%0d", i), 32'(data_a), 32'h0201 + 32'(i - 2));
      @(negedge clk);
    end
    en_a = 1'b0;
    #1;
    check("t5_fread_off", 32'(fread_a), 32'd0);
    check("t5_data_c5", 32'(data_a), 32'h0204);
    @(negedge clk);
    #1;
    check("t5_fread_c6", 32'(fread_a), 32'd0);
    check("t5_valid_c6", 32'(valid_a), 32'd1);
    check("t5_data_c6", 32'(data_a), 32'h0205);
    check("t5_busy_c6", 32'(busy_a), 32'd1);
    @(negedge clk);
    #1;
    check("t5_valid_c7", 32'(valid_a), 32'd0);
    check("t5_busy_c7", 32'(busy_a), 32'd0);
    check("t5_wcnt", 32'(wcnt_a), 32'd5);
    check("t5_fcnt", 32'(fcnt_a), 32'd2);
    wr_a = rd_a;

    // Empty FIFO with en held high
    @(negedge clk);
    en_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      check($sformatf("t6_fread_%0d", i), 32'(fread_a), 32'd0);
      check($sformatf("t6_valid_%0d", i), 32'(valid_a), 32'd0);
      if (i >= 1) check($sformatf("t6_busy_%0d", i), 32'(busy_a), 32'd1);
      @(negedge clk);
    end

    // Framing with FRAME_LEN=4 over 10 words
    load_b(10, 16'h0040);
    en_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      check($sformatf("t4_fread_%0d", i), 32'(fread_b), 32'(i < 10));
      check($sformatf("t4_valid_%0d", i), 32'(valid_b), 32'(i >= 2));
      if (i >= 2) check($sformatf("t4_data_%0d", i), 32'(data_b), 32'h0040 + 32'(i - 2));
      check($sformatf("t4_last_%0d", i), 32'(last_b), 32'((i == 5) || (i == 9)));
      @(negedge clk);
    end
    #1;
    check("t4_valid_end", 32'(valid_b), 32'd0);
    check("t4_fcnt", 32'(fcnt_b), 32'd2);
    check("t4_wcnt", 32'(wcnt_b), 32'd2);

    // Asynchronous reset in the middle of a running stream
    @(negedge clk);
    load_a(4, 16'h0301);
    #1;
    check("t1_fread_c0", 32'(fread_a), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t1_valid_pre", 32'(valid_a), 32'd1);
    check("t1_data_pre", 32'(data_a), 32'h0301);
    check("t1_wcnt_pre", 32'(wcnt_a), 32'd5);
    rst_ = 1'b0;
    #1;
    check("t1_fread", 32'(fread_a), 32'd0);
    check("t1_valid", 32'(valid_a), 32'd0);
    check("t1_last", 32'(last_a), 32'd0);
    check("t1_data", 32'(data_a), 32'd0);
    check("t1_wcnt", 32'(wcnt_a), 32'd0);
    check("t1_fcnt", 32'(fcnt_a), 32'd0);
    check("t1_busy", 32'(busy_a), 32'd0);
    check("t1_b_fcnt", 32'(fcnt_b), 32'd0);
    check("t1_b_wcnt", 32'(wcnt_b), 32'd0);
    check("t1_b_busy", 32'(busy_b), 32'd0);
    @(negedge clk);
    en_a = 1'b0;
    en_b = 1'b0;
    wr_a = rd_a;
    rst_ = 1'b1;
    @(negedge clk);
    #1;
    check("t1_valid_after", 32'(valid_a), 32'd0);
    check("t1_busy_after", 32'(busy_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
